param_register_bank: RTL

- Parametrised successor to the team's single 16-bit function-select register.
- Bank of NUM_REGS registers, each WIDTH bits wide, using the same 3-bit FunSel operation set generalised to half-word lanes.
- Adds multi-register write masking, two combinational read ports, and per-register sticky wrap flags for counter overflow and underflow.
- Serves as the general-purpose/address register file feeding the ALU and memory-address paths of the basic computer.

---
 rtl/param_register_bank.sv | 86 ++++++++
 1 files changed

// File: rtl/param_register_bank.sv
// Bank of NUM_REGS function-select registers with masked writes, two combinational read ports
// and sticky per-register wrap flags; writes land on the clock edge, reads have no bypass.
module param_register_bank #(
   parameter int WIDTH = 16,
   parameter int ADDR_W = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic [WIDTH-1:0]        I,
   input  logic [(2**ADDR_W)-1:0]  RegSel,
   input  logic [2:0]              FunSel,
   input  logic [ADDR_W-1:0]       OutASel,
   input  logic [ADDR_W-1:0]       OutBSel,
   input  logic [(2**ADDR_W)-1:0]  WrapClr,
   output logic [WIDTH-1:0]        OutA,
   output logic [WIDTH-1:0]        OutB,
   output logic [(2**ADDR_W)-1:0]  Wrap
);

   localparam int NUM_REGS = 2**ADDR_W;
   localparam int HALF = WIDTH / 2;

   localparam logic [2:0] FS_DEC   = 3'b000;
   localparam logic [2:0] FS_INC   = 3'b001;
   localparam logic [2:0] FS_LOAD  = 3'b010;
   localparam logic [2:0] FS_CLR   = 3'b011;
   localparam logic [2:0] FS_LOADZ = 3'b100;
   localparam logic [2:0] FS_LOWH  = 3'b101;
   localparam logic [2:0] FS_HIGHH = 3'b110;
   localparam logic [2:0] FS_SEXT  = 3'b111;

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

   logic [WIDTH-1:0]    regs [NUM_REGS];
   logic [WIDTH-1:0]    regs_nxt [NUM_REGS];
   logic [NUM_REGS-1:0] wrap_q;
   logic [NUM_REGS-1:0] wrap_set;

   always_comb begin
      for (int k = 0; k < NUM_REGS; k++) begin
         regs_nxt[k] = regs[k];
         wrap_set[k] = 1'b0;
         if (RegSel[k]) begin
            case (FunSel)
               FS_DEC: begin
                  regs_nxt[k] = regs[k] - ONE;
                  wrap_set[k] = (regs[k] == '0);
               end
               FS_INC: begin
                  regs_nxt[k] = regs[k] + ONE;
                  wrap_set[k] = (regs[k] == ONES);
               end
               FS_LOAD:  regs_nxt[k] = I;
               FS_CLR:   regs_nxt[k] = '0;
               FS_LOADZ: regs_nxt[k] = {{HALF{1'b0}}, I[HALF-1:0]};
               FS_LOWH:  regs_nxt[k] = {regs[k][WIDTH-1:HALF], I[HALF-1:0]};
               FS_HIGHH: regs_nxt[k] = {I[HALF-1:0], regs[k][HALF-1:0]};
               FS_SEXT:  regs_nxt[k] = {{HALF{I[HALF-1]}}, I[HALF-1:0]};
               default:  regs_nxt[k] = regs[k];
            endcase
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs[k] <= RESET_VAL;
         end
         wrap_q <= '0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs[k] <= regs_nxt[k];
         end
         // a wrap on the same edge as a clear request keeps the flag set
         wrap_q <= (wrap_q & ~WrapClr) | wrap_set;
      end
   end

   assign OutA = regs[OutASel];
   assign OutB = regs[OutBSel];
   assign Wrap = wrap_q;

endmodule
